rc4_ksa_shuffler: RTL
=====================

# rc4_ksa_shuffler

Key-scheduling (KSA) shuffle engine for the RC4 core: after the S array has been initialised to the identity, this block performs the 256-iteration swap loop `j = j + S[i] + key[i mod 3]` and swaps `S[i]` and `S[j]` in the shared single-port S RAM. It is the consumer side of the key-byte selection path. It drives the byte index onto `key_index`. It samples the returned `key_byte`, which is produced combinationally from `secret_key` by the key byte selector. Control is a start/done handshake from the top-level cracking FSM.

## Interface
- No parameters. Key length is fixed at 3 bytes and the S array is fixed at 256 x 8.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request one full KSA pass; sampled only in IDLE.
- `done` output 1: one-cycle pulse when the pass is complete.
- `key_index` output 8: current i, sent to the key byte selector.
- `key_byte` input 8: `secret_key[i mod 3]`, combinational from the selector, valid in the same cycle as `key_index`.
- `s_address` output 8: S RAM address.
- `s_data` output 8: S RAM write data.
- `s_wren` output 1: S RAM write enable.
- `s_q` input 8: S RAM read data. This is a registered read: data for the address presented in cycle N is valid in cycle N+1.

## Operation
- Registers:
  - i[7:0], j[7:0], si[7:0], sj[7:0].
  - State takes values IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE.
- Output decode:
  - `key_index` always equals i.
  - `s_wren` is high only in WR_I and WR_J.
  - `s_data` is 0 outside those two states.
- State transitions:
  - IDLE: on `start` = 1, clear i and j to 0 and go to RD_I. Otherwise stay in IDLE.
  - RD_I: drive `s_address` = i, then go to LAT_I.
  - LAT_I: capture si = `s_q`. Compute j = (j + `s_q` + `key_byte`) mod 256, truncating to 8 bits with carries discarded. Go to RD_J.
  - RD_J: drive `s_address` = j (the new value), then go to LAT_J.
  - LAT_J: capture sj = `s_q`, then go to WR_I.
  - WR_I: drive `s_address` = i, `s_data` = sj, `s_wren` = 1, then go to WR_J.
  - WR_J: drive `s_address` = j, `s_data` = si, `s_wren` = 1.
    - If i == 255, go to DONE.
    - Otherwise set i = i + 1 and go to RD_I.
  - DONE: `done` = 1 for this cycle only, then go to IDLE. i is not incremented past 255; i and j hold their final values.
- Boundary cases:
  - i == j: both writes target the same address with the same value (si == sj). The final RAM content equals the old value, so no special handling is needed.
  - j wraps mod 256, e.g. 0xFF + 0x02 + 0x00 = 0x01.
  - `start` while not in IDLE is ignored and not queued. `start` held high through DONE starts a new pass from IDLE on the next sample.
- Reset (asynchronous, mid-operation included):
  - Forces IDLE with i = j = si = sj = 0.
  - All outputs go to 0: `done`, `s_wren`, `s_address`, `s_data`, `key_index`.
  - RAM contents after an aborted pass are undefined. The upper FSM must re-initialise S.

## Timing
- Each iteration takes 6 cycles (RD_I through WR_J). A full pass is 256 x 6 = 1536 cycles.
- With `start` sampled high at clock edge k:
  - RD_I (i = 0) occupies cycle k+1.
  - `done` is high in cycle k+1537, for exactly one cycle.
  - Back in IDLE at cycle k+1538.
- RAM access per iteration: exactly 2 reads, then 2 writes. Writes are never back-to-back with a read to the same address except as listed above.
- `key_byte` must settle within the cycle. The selector path is combinational, and `key_byte` is sampled only in LAT_I.

## Test plan
- Key 24'h010203, S initialised to identity:
  - iteration 0 computes j = 0x01 and writes S[0] = 0x01, then S[1] = 0x00;
  - `key_index` = 0 in RD_I;
  - the full final S matches the software RC4 KSA model.
- Key 24'h000000, S = identity:
  - iteration 0 has i == j == 0 and writes 0x00 to address 0 twice;
  - iteration 2 has j = 0x03 and swaps S[2] and S[3].
- Key 24'hFFFFFF, S = identity:
  - iteration 0 computes j = 0xFF, giving S[0] = 0xFF and S[0xFF] = 0x00;
  - later j sums wrap mod 256 and the final S matches the model.
- Latency: pulse `start` at edge k -> `done` high only in cycle k+1537, and `s_wren` is asserted exactly 512 times in total.
- `start` re-asserted at cycle k+100 -> ignored; the pass is unaffected and only one `done` pulse appears.
- `reset` asserted asynchronously at cycle k+700 -> all outputs go to 0 immediately and the block returns to IDLE. A fresh `start` after re-initialising S gives a correct full pass.

Source files
------------

// File: rtl/rc4_ksa_shuffler.sv
// RC4 key-scheduling shuffle: 256 iterations of j += S[i] + key[i mod 3], swap S[i]/S[j],
// against a single-port S RAM with a one-cycle registered read.
module rc4_ksa_shuffler (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] key_index,
  input  logic [7:0] key_byte,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q
);

  typedef enum logic [2:0] {
    StIdle,
    StRdI,
    StLatI,
    StRdJ,
    StLatJ,
    StWrI,
    StWrJ,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  assign key_index = i_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    s_address = 8'd0;
    s_data    = 8'd0;
    s_wren    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          state_d = StRdI;
        end
      end
      StRdI: begin
        s_address = i_q;
        state_d   = StLatI;
      end
      StLatI: begin
        // s_q holds S[i] here; key_byte is valid for key_index == i this cycle.
        si_d    = s_q;
        j_d     = j_q + s_q + key_byte;
        state_d = StRdJ;
      end
      StRdJ: begin
        s_address = j_q;
        state_d   = StLatJ;
      end
      StLatJ: begin
        sj_d    = s_q;
        state_d = StWrI;
      end
      StWrI: begin
        s_address = i_q;
        s_data    = sj_q;
        s_wren    = 1'b1;
        state_d   = StWrJ;
      end
      StWrJ: begin
        // When i == j both writes carry the same value, so the second one is harmless.
        s_address = j_q;
        s_data    = si_q;
        s_wren    = 1'b1;
        if (i_q == 8'hff) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = StRdI;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
